// File: rtl/relu_vector_sequencer_pkg.sv
// Shared types and helpers for the ReLU vector sequencer.
package relu_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Signed ReLU: negative inputs clip to zero, everything else passes through.
    function automatic logic [DEFAULT_DATA_W-1:0] relu_f(input logic signed [DEFAULT_DATA_W-1:0] din);
        return (din < 0) ? '0 : din;
    endfunction

endpackage

// File: rtl/relu_vector_sequencer_stage.sv
// One registered ReLU stage: takes a valid read word, registers its ReLU
// result plus a flag saying whether the input was negative.
module relu_stage
    import relu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic              out_clip
);

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              clip_q, clip_d;
    logic [DATA_W-1:0] relu_res;

    if (DATA_W == DEFAULT_DATA_W) begin : g_pkg_relu
        assign relu_res = relu_f(in_data);
    end else begin : g_generic_relu
        assign relu_res = in_data[DATA_W-1] ? '0 : in_data;
    end

    // Next-state: capture a new result only when the input word is valid.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        vld_d  = in_vld && !flush;
        data_d = data_q;
        clip_d = clip_q;
        if (in_vld) begin
            data_d = relu_res;
            clip_d = in_data[DATA_W-1];
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks so all flops see pre-edge values.
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            clip_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            clip_q <= clip_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_data = data_q;
    assign out_clip = clip_q;

endmodule

// File: rtl/relu_vector_sequencer.sv
// Sequences one ReLU pass over a vector held in the activation buffer:
// reads LEN words from a source base, writes ReLU results from a
// destination base, and counts negative (clipped) elements.
module relu_vector_sequencer
    import relu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_rd_base,
    input  logic [ADDR_W-1:0] cfg_wr_base,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [LEN_W-1:0]  clip_count
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
    // Write index is address-wide so destination addresses wrap for free.
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic              rd_vld_q, rd_vld_d;
    logic [LEN_W-1:0]  clip_count_q, clip_count_d;

    logic start_ok;
    logic flush;
    logic stg_vld;
    logic stg_clip;
    logic [DATA_W-1:0] stg_data;

    // Abort beats start when both arrive in IDLE; abort only matters while busy.
    assign start_ok = start && !abort && (state_q == IDLE);
    assign flush    = abort && ((state_q == RUN) || (state_q == DRAIN));

    // Next-state logic: FSM, index counters, config capture and clip counter.
    always_comb begin
        state_d      = state_q;
        rd_base_d    = rd_base_q;
        wr_base_d    = wr_base_q;
        len_d        = len_q;
        rd_idx_d     = rd_idx_q;
        wr_idx_d     = wr_idx_q;
        rd_vld_d     = 1'b0;
        clip_count_d = clip_count_q;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    rd_base_d    = cfg_rd_base;
                    wr_base_d    = cfg_wr_base;
                    len_d        = cfg_len;
                    rd_idx_d     = '0;
                    wr_idx_d     = '0;
                    clip_count_d = '0;
                    state_d      = (cfg_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                rd_vld_d = 1'b1;
                rd_idx_d = rd_idx_q + LEN_W'(1);
                if (rd_idx_q == len_q - LEN_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Once the last read has left the first pipeline slot, the
                // ReLU stage is writing the final element this cycle.
                if (!rd_vld_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Writes and clip counting happen at the output of the ReLU stage.
        if (stg_vld) begin
            wr_idx_d = wr_idx_q + ADDR_W'(1);
            if (stg_clip && (clip_count_q != '1)) begin
                clip_count_d = clip_count_q + LEN_W'(1);
            end
        end

        // Abort drops everything in flight; the partial clip count is kept.
        if (flush) begin
            state_d  = IDLE;
            rd_vld_d = 1'b0;
        end
    end

    // Control and datapath-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_base_q    <= '0;
            wr_base_q    <= '0;
            len_q        <= '0;
            rd_idx_q     <= '0;
            wr_idx_q     <= '0;
            rd_vld_q     <= 1'b0;
            clip_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_base_q    <= rd_base_d;
            wr_base_q    <= wr_base_d;
            len_q        <= len_d;
            rd_idx_q     <= rd_idx_d;
            wr_idx_q     <= wr_idx_d;
            rd_vld_q     <= rd_vld_d;
            clip_count_q <= clip_count_d;
        end
    end

    relu_stage #(
        .DATA_W (DATA_W)
    ) u_relu_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (rd_vld_q),
        .in_data  (rd_data),
        .out_vld  (stg_vld),
        .out_data (stg_data),
        .out_clip (stg_clip)
    );

    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign rd_en      = (state_q == RUN);
    assign rd_addr    = rd_base_q + rd_idx_q[ADDR_W-1:0];
    assign wr_en      = stg_vld;
    assign wr_addr    = wr_base_q + wr_idx_q;
    assign wr_data    = stg_data;
    assign clip_count = clip_count_q;

endmodule

// File: tb/tb_relu_vector_sequencer.sv
// Self-checking bench for relu_vector_sequencer: table of directed passes,
// randomized passes against a cycle-level reference model, and hand-written
// corner sequences (abort+start, async reset mid-pass).
module tb_relu_vector_sequencer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 11;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CLIP_MAX = (1 << LEN_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] cfg_rd_base = '0;
    logic [ADDR_W-1:0] cfg_wr_base = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              abort = 1'b0;
    logic              busy, done, rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] wr_data;
    logic [LEN_W-1:0]  clip_count;

    logic [DATA_W-1:0] mem [DEPTH];

    int errors = 0;
    int checks = 0;
    int last_clip = 0;

    typedef struct {
        logic [ADDR_W-1:0] rd_base;
        logic [ADDR_W-1:0] wr_base;
        int len;
        int fill;        // 0 random, 1 [5,0,-1,max] pattern, 2 all 0x80000000
        int abort_at;    // cycle in which abort is high, 0 = never
        int restart_at;  // cycle in which a stray start is pulsed, 0 = never
        bit hold;        // keep start high until after the DONE cycle
        int exp_clip;    // -1 = model only
        int exp_done;    // -1 = model only
    } vec_t;

    vec_t vecs[7];

    relu_vector_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_rd_base (cfg_rd_base),
        .cfg_wr_base (cfg_wr_base),
        .cfg_len     (cfg_len),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clip_count  (clip_count)
    );

    always #5 clk = ~clk;

    // Buffer read port: data one cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_relu(input logic [DATA_W-1:0] x);
        return ($signed(x) > 0) ? x : '0;
    endfunction

    function automatic logic [DATA_W-1:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h0;
            2: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Run one pass and check every cycle against the reference timeline.
    task automatic run_pass(input vec_t v, input string tag);
        int L, k, mdone, last, neg, done_at, idx;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] exp_a;
        bit alive, exp_rd, exp_wr, exp_busy, exp_done;
        L = v.len;
        k = v.abort_at;
        mdone = (k != 0) ? -1 : ((L == 0) ? 1 : L + 3);
        last  = (L == 0) ? 4 : ((k != 0) ? k + 3 : L + 5);
        neg = 0;
        done_at = -1;

        for (int i = 0; i < L; i++) begin
            a = ADDR_W'((int'(v.rd_base) + i) % DEPTH);
            case (v.fill)
                1: begin
                    case (i % 4)
                        0: mem[a] = 32'd5;
                        1: mem[a] = 32'd0;
                        2: mem[a] = 32'hFFFF_FFFF;
                        default: mem[a] = 32'h7FFF_FFFF;
                    endcase
                end
                2: mem[a] = 32'h8000_0000;
                default: mem[a] = rand_word();
            endcase
        end

        @(negedge clk);
        cfg_rd_base = v.rd_base;
        cfg_wr_base = v.wr_base;
        cfg_len     = LEN_W'(L);
        start       = 1'b1;
        @(posedge clk);  // edge 0

        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            start = (v.hold && c <= mdone) || (c == v.restart_at);
            abort = (c == k);
            // Config inputs change after acceptance; the DUT must ignore them.
            cfg_rd_base = ADDR_W'($urandom);
            cfg_wr_base = ADDR_W'($urandom);
            cfg_len     = LEN_W'($urandom_range(1, 50));

            alive    = (k == 0) || (c <= k);
            exp_rd   = alive && (c <= L);
            exp_wr   = alive && (c >= 3) && (c <= L + 2);
            exp_busy = alive && (L > 0) && (c <= L + 2);
            exp_done = (c == mdone);

            check($sformatf("%s c%0d rd_en", tag, c), 32'(rd_en), 32'(exp_rd));
            check($sformatf("%s c%0d wr_en", tag, c), 32'(wr_en), 32'(exp_wr));
            check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(exp_busy));
            check($sformatf("%s c%0d done", tag, c), 32'(done), 32'(exp_done));
            if (done && done_at < 0) done_at = c;
            if (exp_rd) begin
                exp_a = ADDR_W'((int'(v.rd_base) + c - 1) % DEPTH);
                check($sformatf("%s c%0d rd_addr", tag, c), 32'(rd_addr), 32'(exp_a));
            end
            if (exp_wr) begin
                idx   = c - 3;
                a     = ADDR_W'((int'(v.rd_base) + idx) % DEPTH);
                exp_a = ADDR_W'((int'(v.wr_base) + idx) % DEPTH);
                check($sformatf("%s c%0d wr_addr", tag, c), 32'(wr_addr), 32'(exp_a));
                check($sformatf("%s c%0d wr_data", tag, c), wr_data, ref_relu(mem[a]));
                if ($signed(mem[a]) < 0) neg++;
            end
        end
        start = 1'b0;
        abort = 1'b0;

        last_clip = (neg > CLIP_MAX) ? CLIP_MAX : neg;
        check($sformatf("%s clip_count", tag), 32'(clip_count), 32'(last_clip));
        if (v.exp_clip >= 0)
            check($sformatf("%s clip_count table", tag), 32'(clip_count), 32'(v.exp_clip));
        if (v.exp_done >= 0)
            check($sformatf("%s done cycle", tag), 32'(done_at), 32'(v.exp_done));
    endtask

    initial begin
        vec_t rv;

        vecs[0] = '{rd_base: 10'h3F0, wr_base: 10'h100, len: 4,    fill: 1, abort_at: 0, restart_at: 0, hold: 1'b0, exp_clip: 1,    exp_done: 7};
        vecs[1] = '{rd_base: 10'h000, wr_base: 10'h000, len: 0,    fill: 0, abort_at: 0, restart_at: 0, hold: 1'b0, exp_clip: 0,    exp_done: 1};
        vecs[2] = '{rd_base: 10'h3FE, wr_base: 10'h3FF, len: 3,    fill: 0, abort_at: 0, restart_at: 0, hold: 1'b0, exp_clip: -1,   exp_done: 6};
        vecs[3] = '{rd_base: 10'h010, wr_base: 10'h200, len: 8,    fill: 2, abort_at: 2, restart_at: 0, hold: 1'b0, exp_clip: 0,    exp_done: -1};
        vecs[4] = '{rd_base: 10'h050, wr_base: 10'h300, len: 6,    fill: 0, abort_at: 0, restart_at: 2, hold: 1'b0, exp_clip: -1,   exp_done: 9};
        vecs[5] = '{rd_base: 10'h000, wr_base: 10'h3FF, len: 1024, fill: 2, abort_at: 0, restart_at: 0, hold: 1'b0, exp_clip: 1024, exp_done: 1027};
        vecs[6] = '{rd_base: 10'h123, wr_base: 10'h045, len: 2,    fill: 0, abort_at: 0, restart_at: 0, hold: 1'b1, exp_clip: -1,   exp_done: 5};

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

        // Reset state.
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset rd_en", 32'(rd_en), 32'd0);
        check("reset rd_addr", 32'(rd_addr), 32'd0);
        check("reset wr_en", 32'(wr_en), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset wr_data", wr_data, 32'd0);
        check("reset clip_count", 32'(clip_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_pass(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            rv.rd_base    = ADDR_W'($urandom);
            rv.wr_base    = ADDR_W'($urandom);
            rv.len        = $urandom_range(1, 40);
            rv.fill       = 0;
            rv.abort_at   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rv.len + 2) : 0;
            rv.restart_at = 0;
            rv.hold       = 1'b0;
            rv.exp_clip   = -1;
            rv.exp_done   = -1;
            run_pass(rv, $sformatf("rnd%0d", i));
        end

        // Abort and start together in IDLE: start ignored, clip count untouched.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        cfg_len = LEN_W'(4);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort+start busy", 32'(busy), 32'd0);
        check("abort+start rd_en", 32'(rd_en), 32'd0);
        check("abort+start done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort+start later busy", 32'(busy), 32'd0);
        check("abort+start clip held", 32'(clip_count), 32'(last_clip));

        // Async reset mid-pass: strobes drop at once, no done afterwards.
        @(negedge clk);
        cfg_rd_base = '0;
        cfg_wr_base = '0;
        cfg_len = LEN_W'(8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset wr_en", 32'(wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset rd_en", 32'(rd_en), 32'd0);
        check("mid reset wr_en", 32'(wr_en), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset clip_count", 32'(clip_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("post reset c%0d done", c), 32'(done), 32'd0);
            check($sformatf("post reset c%0d busy", c), 32'(busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
